// File: rtl/task_out_pkg.sv
// Shared types, constants and helpers for the task_out_packer result stage.
package task_out_pkg;

   typedef enum logic {COLLECT, SEND} packer_state_t;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned PKT_SIZE_W     = 12;

   // ceil(n/4); one extra bit of headroom so n near 4095 cannot wrap.
   function automatic logic [PKT_SIZE_W-1:0] words_for_bytes(input logic [PKT_SIZE_W-1:0] n);
      logic [PKT_SIZE_W:0] sum;
      sum = {1'b0, n} + (PKT_SIZE_W+1)'(BYTES_PER_WORD - 1);
      return sum[PKT_SIZE_W:2];
   endfunction

endpackage

// File: rtl/task_out_word_buf.sv
// Reset-free word buffer: byte-lane writes, combinational read by word index.
module task_out_word_buf
   import task_out_pkg::*;
#(
   parameter int unsigned DEPTH  = 25,
   parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                      clk_i,
   input  logic                      we_i,
   input  logic [ADDR_W-1:0]         waddr_i,
   input  logic [BYTES_PER_WORD-1:0] wbe_i,
   input  logic [WORD_W-1:0]         wdata_i,
   input  logic [ADDR_W-1:0]         raddr_i,
   output logic [WORD_W-1:0]         rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   // Write only the enabled byte lanes of the addressed word.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int l = 0; l < int'(BYTES_PER_WORD); l++) begin
            if (wbe_i[l]) begin
               mem_q[waddr_i][l*BYTE_W +: BYTE_W] <= wdata_i[l*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/task_out_packer.sv
// Packs a packet of result bytes into 32-bit words, then replays them to the
// task manager with a ready/ready handshake, last-word flag and byte count.
// Optional: define TASK_OUT_PACKER_BIG_ENDIAN_EN to place byte 0 in bits [31:24].
module task_out_packer
   import task_out_pkg::*;
#(
   parameter int unsigned WRITE_DATA_WIDTH = 8,
   parameter int unsigned READ_DATA_WIDTH  = 32,
   parameter int unsigned NUM_WORDS        = 100
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [WRITE_DATA_WIDTH-1:0] i_data,
   input  logic                        i_data_valid,
   input  logic                        i_input_last,
   input  logic                        i_tmanager_ready,
   output logic                        o_tanswer_ready,
   output logic [READ_DATA_WIDTH-1:0]  o_tdata,
   output logic                        o_tanswer_data_last,
   output logic [PKT_SIZE_W-1:0]       o_packet_size_in_bytes,
   output logic                        o_overflow
);

   localparam int unsigned BufDepth = (NUM_WORDS + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
   localparam int unsigned AddrW    = (BufDepth > 1) ? $clog2(BufDepth) : 1;

   if (WRITE_DATA_WIDTH != BYTE_W) begin : g_bad_write_width
      $error("task_out_packer: WRITE_DATA_WIDTH must be 8");
   end
   if (READ_DATA_WIDTH != WORD_W) begin : g_bad_read_width
      $error("task_out_packer: READ_DATA_WIDTH must be 32");
   end
   if (NUM_WORDS < 1 || NUM_WORDS > 4095) begin : g_bad_depth
      $error("task_out_packer: NUM_WORDS must be in 1..4095");
   end

   packer_state_t            state_q, state_d;
   logic [PKT_SIZE_W-1:0]    byte_cnt_q, byte_cnt_d;
   logic [PKT_SIZE_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PKT_SIZE_W-1:0]    pkt_size_q, pkt_size_d;
   logic                     overflow_q, overflow_d;

   logic [PKT_SIZE_W-1:0]    num_words;
   logic                     is_last_word;
   logic                     has_room;
   logic                     wr_en;
   logic [1:0]               wr_lane;
   logic [BYTES_PER_WORD-1:0] wr_be;
   logic [WORD_W-1:0]        rd_word;
   logic [BYTES_PER_WORD-1:0] lane_valid;
   logic [WORD_W-1:0]        lane_mask;

   assign num_words    = words_for_bytes(pkt_size_q);
   assign is_last_word = (rd_ptr_q == num_words - PKT_SIZE_W'(1));
   assign has_room     = (byte_cnt_q < PKT_SIZE_W'(NUM_WORDS));

   // Logical byte lane -> physical lane inside the word.
`ifdef TASK_OUT_PACKER_BIG_ENDIAN_EN
   assign wr_lane = ~byte_cnt_q[1:0];
`else
   assign wr_lane = byte_cnt_q[1:0];
`endif
   assign wr_be = BYTES_PER_WORD'(1) << wr_lane;

   task_out_word_buf #(
      .DEPTH  (BufDepth),
      .ADDR_W (AddrW)
   ) u_word_buf (
      .clk_i   (i_clk),
      .we_i    (wr_en),
      .waddr_i (byte_cnt_q[AddrW+1:2]),
      .wbe_i   (wr_be),
      .wdata_i ({BYTES_PER_WORD{i_data}}),
      .raddr_i (rd_ptr_q[AddrW-1:0]),
      .rdata_o (rd_word)
   );

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= COLLECT;
         byte_cnt_q <= '0;
         rd_ptr_q   <= '0;
         pkt_size_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         pkt_size_q <= pkt_size_d;
         overflow_q <= overflow_d;
      end
   end

   // Next-state logic: collect bytes until last, then drain words on handshake.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      pkt_size_d = pkt_size_q;
      overflow_d = overflow_q;
      wr_en      = 1'b0;
      unique case (state_q)
         COLLECT: begin
            if (i_data_valid) begin
               if (has_room) begin
                  wr_en      = 1'b1;
                  byte_cnt_d = byte_cnt_q + PKT_SIZE_W'(1);
               end else begin
                  overflow_d = 1'b1;
               end
               if (i_input_last) begin
                  state_d    = SEND;
                  rd_ptr_d   = '0;
                  pkt_size_d = has_room ? byte_cnt_q + PKT_SIZE_W'(1) : byte_cnt_q;
               end
            end
         end
         SEND: begin
            // Incoming bytes are dropped here without flagging overflow.
            if (i_tmanager_ready) begin
               if (is_last_word) begin
                  state_d    = COLLECT;
                  rd_ptr_d   = '0;
                  byte_cnt_d = '0;
                  overflow_d = 1'b0;
               end else begin
                  rd_ptr_d = rd_ptr_q + PKT_SIZE_W'(1);
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Zero the unused lanes of a partial final word; stale buffer data may sit there.
   always_comb begin
      lane_valid = '1;
      lane_mask  = '0;
      if (is_last_word) begin
         unique case (pkt_size_q[1:0])
            2'd1:    lane_valid = 4'b0001;
            2'd2:    lane_valid = 4'b0011;
            2'd3:    lane_valid = 4'b0111;
            default: lane_valid = 4'b1111;
         endcase
      end
      for (int l = 0; l < int'(BYTES_PER_WORD); l++) begin
`ifdef TASK_OUT_PACKER_BIG_ENDIAN_EN
         lane_mask[(3-l)*BYTE_W +: BYTE_W] = {BYTE_W{lane_valid[l]}};
`else
         lane_mask[l*BYTE_W +: BYTE_W] = {BYTE_W{lane_valid[l]}};
`endif
      end
   end

   // Outputs are functions of registered state only.
   always_comb begin
      o_tanswer_ready        = (state_q == SEND);
      o_tanswer_data_last    = o_tanswer_ready && is_last_word;
      o_tdata                = o_tanswer_ready ? (rd_word & lane_mask) : '0;
      o_packet_size_in_bytes = pkt_size_q;
      o_overflow             = overflow_q;
   end

endmodule

// File: tb/tb_task_out_packer.sv
// Randomised self-checking bench for task_out_packer against a byte-queue model.
module tb_task_out_packer;

   localparam int unsigned NW = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data;
   logic        data_valid;
   logic        input_last;
   logic        tm_ready;
   logic        ans_ready;
   logic [31:0] tdata;
   logic        data_last;
   logic [11:0] pkt_size;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   task_out_packer #(
      .WRITE_DATA_WIDTH (8),
      .READ_DATA_WIDTH  (32),
      .NUM_WORDS        (NW)
   ) dut (
      .i_clk                  (clk),
      .i_rst                  (rst),
      .i_data                 (data),
      .i_data_valid           (data_valid),
      .i_input_last           (input_last),
      .i_tmanager_ready       (tm_ready),
      .o_tanswer_ready        (ans_ready),
      .o_tdata                (tdata),
      .o_tanswer_data_last    (data_last),
      .o_packet_size_in_bytes (pkt_size),
      .o_overflow             (overflow)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Feed one packet, optionally with idle cycles that carry a stray last flag.
   task automatic collect(input logic [7:0] bytes_in[$], input bit gaps);
      for (int i = 0; i < bytes_in.size(); i++) begin
         if (gaps && $urandom_range(3) == 0) begin
            data_valid = 1'b0;
            input_last = 1'($urandom_range(1));
            data       = 8'($urandom);
            step();
            check_eq("idle_rdy", 32'(ans_ready), 32'd0);
         end
         data_valid = 1'b1;
         data       = bytes_in[i];
         input_last = (i == bytes_in.size() - 1);
         step();
         if (i != bytes_in.size() - 1) check_eq("col_rdy", 32'(ans_ready), 32'd0);
      end
      data_valid = 1'b0;
      input_last = 1'b0;
      check_eq("lat_rdy", 32'(ans_ready), 32'd1);
   endtask

   // Expected words from the packet rules: first NW bytes kept, 4 per word, zero pad.
   task automatic build_words(input logic [7:0] bytes_in[$], output logic [31:0] words[$],
                              output int stored, output bit ovf);
      int nwords;
      stored = (bytes_in.size() > int'(NW)) ? int'(NW) : bytes_in.size();
      ovf    = bytes_in.size() > int'(NW);
      nwords = (stored + 3) / 4;
      words.delete();
      for (int w = 0; w < nwords; w++) begin
         logic [31:0] word;
         word = '0;
         for (int k = 0; k < 4; k++) begin
            logic [31:0] b;
            b = (4*w + k < stored) ? 32'(bytes_in[4*w+k]) : 32'd0;
`ifdef TASK_OUT_PACKER_BIG_ENDIAN_EN
            word = word | (b << (24 - 8*k));
`else
            word = word | (b << (8*k));
`endif
         end
         words.push_back(word);
      end
   endtask

   // Drain and check the packet; ready pattern or random; optional junk input.
   task automatic expect_send(input logic [7:0] bytes_in[$], input logic [31:0] rdy_pat,
                              input bit use_pat, input bit junk, output int cycles);
      logic [31:0] words[$];
      int stored;
      bit ovf;
      int idx;
      bit tr;
      build_words(bytes_in, words, stored, ovf);
      idx    = 0;
      cycles = 0;
      while (idx < words.size() && cycles < 200) begin
         check_eq("snd_rdy", 32'(ans_ready), 32'd1);
         check_eq("snd_data", tdata, words[idx]);
         check_eq("snd_last", 32'(data_last), 32'(idx == words.size() - 1));
         check_eq("snd_size", 32'(pkt_size), 32'(stored));
         check_eq("snd_ovf", 32'(overflow), 32'(ovf));
         tr = use_pat ? ((cycles < 32) ? rdy_pat[cycles] : 1'b1) : 1'($urandom_range(1));
         tm_ready = tr;
         if (junk) begin
            data_valid = 1'($urandom_range(1));
            data       = 8'($urandom);
            input_last = 1'($urandom_range(1));
         end
         step();
         cycles++;
         if (tr) idx++;
      end
      if (idx < words.size()) check_eq("send_timeout", 32'(idx), 32'(words.size()));
      tm_ready   = 1'b0;
      data_valid = 1'b0;
      input_last = 1'b0;
      check_eq("end_rdy", 32'(ans_ready), 32'd0);
      check_eq("end_last", 32'(data_last), 32'd0);
      check_eq("end_ovf", 32'(overflow), 32'd0);
      check_eq("end_size", 32'(pkt_size), 32'(stored));
   endtask

   initial begin
      logic [7:0] q[$];
      int cyc;
      rst        = 1'b0;
      data       = '0;
      data_valid = 1'b0;
      input_last = 1'b0;
      tm_ready   = 1'b0;
      step();
      step();
      check_eq("rst_rdy", 32'(ans_ready), 32'd0);
      check_eq("rst_data", tdata, 32'd0);
      check_eq("rst_last", 32'(data_last), 32'd0);
      check_eq("rst_size", 32'(pkt_size), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b1;
      step();

      // Five bytes, manager always ready.
      q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      collect(q, 1'b0);
      expect_send(q, 32'hFFFF_FFFF, 1'b1, 1'b0, cyc);
      check_eq("t1_cycles", 32'(cyc), 32'd2);

      // Eight bytes with stalls 1,0,0,1.
      q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      collect(q, 1'b0);
      expect_send(q, 32'b1001, 1'b1, 1'b0, cyc);
      check_eq("t2_cycles", 32'(cyc), 32'd4);

      // Overflow: 13 bytes into a 10-byte buffer.
      q.delete();
      for (int i = 0; i < 13; i++) q.push_back(8'(8'hA0 + i));
      collect(q, 1'b0);
      check_eq("t3_ovf_set", 32'(overflow), 32'd1);
      expect_send(q, 32'd0, 1'b0, 1'b0, cyc);

      // Single byte, junk input during send must not leak into next packet.
      q = {8'hAA};
      collect(q, 1'b0);
      check_eq("t4_last_now", 32'(data_last), 32'd1);
      expect_send(q, 32'b0110, 1'b1, 1'b1, cyc);

      // Exactly full buffer: no overflow, partial final word.
      q.delete();
      for (int i = 0; i < int'(NW); i++) q.push_back(8'($urandom));
      collect(q, 1'b0);
      expect_send(q, 32'd0, 1'b0, 1'b1, cyc);

      // Reset in the middle of a 3-word send.
      q.delete();
      for (int i = 0; i < int'(NW); i++) q.push_back(8'(8'h30 + i));
      collect(q, 1'b0);
      check_eq("t5_w0", tdata, 32'h3332_3130);
      tm_ready = 1'b1;
      step();
      tm_ready = 1'b0;
      rst      = 1'b0;
      step();
      check_eq("t5_rst_rdy", 32'(ans_ready), 32'd0);
      check_eq("t5_rst_data", tdata, 32'd0);
      check_eq("t5_rst_last", 32'(data_last), 32'd0);
      check_eq("t5_rst_size", 32'(pkt_size), 32'd0);
      check_eq("t5_rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b1;
      q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
      collect(q, 1'b0);
      expect_send(q, 32'd0, 1'b0, 1'b0, cyc);

      // Random packets with gaps, random back-pressure and junk during send.
      for (int p = 0; p < 40; p++) begin
         int len;
         len = $urandom_range(14, 1);
         q.delete();
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         collect(q, 1'b1);
         expect_send(q, 32'd0, 1'b0, 1'b1, cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
